// File: rtl/hit_payload_framer.sv
// Captures PAYLOAD_W serial bits after each detector hit and presents them as a word on a valid/ready port.
// Keeps saturating counts of frames started and of completed frames dropped because the output word was still pending.
module hit_payload_framer #(
  parameter int PAYLOAD_W = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_in,
  input  logic                 hit,
  input  logic                 clear_stats,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [PAYLOAD_W-1:0] m_data,
  output logic [CNT_W-1:0]     frame_count,
  output logic [CNT_W-1:0]     drop_count,
  output logic                 overflow
);

  localparam int BC_W = $clog2(PAYLOAD_W + 1);
  localparam logic [BC_W-1:0]  LAST_CNT = BC_W'(PAYLOAD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [BC_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic [PAYLOAD_W-1:0] shreg, shreg_nxt;
  logic [PAYLOAD_W-1:0] shifted;
  logic                 frame_start;
  logic                 frame_done;
  logic                 out_free;
  logic                 drop;

  // First bit enters at the LSB and ends up in the MSB after PAYLOAD_W shifts.
  assign shifted  = {shreg[PAYLOAD_W-2:0], bit_in};
  assign out_free = !m_valid || m_ready;
  assign drop     = frame_done && !out_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          state_nxt   = CAPTURE;
          bit_cnt_nxt = BC_W'(1);
          shreg_nxt   = shifted;
          frame_start = 1'b1;
        end
      end
      CAPTURE: begin
        // hit is deliberately not looked at here; overlapping matches never restart a frame.
        shreg_nxt = shifted;
        if (bit_cnt == LAST_CNT) begin
          state_nxt   = IDLE;
          bit_cnt_nxt = '0;
          frame_done  = 1'b1;
        end else begin
          bit_cnt_nxt = bit_cnt + BC_W'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  // A completing frame may reuse the register in the same cycle the consumer pops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (frame_done && out_free) begin
      m_valid <= 1'b1;
      m_data  <= shifted;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      frame_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (frame_start && frame_count != CNT_MAX) begin
        frame_count <= frame_count + CNT_W'(1);
      end
      if (drop && drop_count != CNT_MAX) begin
        drop_count <= drop_count + CNT_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hit_payload_framer.sv
// Bench for hit_payload_framer: directed scenarios plus a random phase, all checked against a queue-based model.
module tb_hit_payload_framer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, bit_in, hit, clear_stats, m_ready;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic [15:0]  frame_count, drop_count;
  logic         overflow;
  logic         s_valid;
  logic [W-1:0] s_data;
  logic [1:0]   s_frames, s_drops;
  logic         s_ovf;

  always #5 clk = ~clk;

  hit_payload_framer #(.PAYLOAD_W(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .hit(hit), .clear_stats(clear_stats),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .frame_count(frame_count), .drop_count(drop_count), .overflow(overflow)
  );

  hit_payload_framer #(.PAYLOAD_W(W), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .bit_in(bit_in), .hit(hit), .clear_stats(clear_stats),
    .m_valid(s_valid), .m_ready(m_ready), .m_data(s_data),
    .frame_count(s_frames), .drop_count(s_drops), .overflow(s_ovf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a frame is just a queue of collected bits.
  bit           capturing;
  bit           cap_q[$];
  bit           exp_valid;
  logic [W-1:0] exp_data;
  int           frames, drops;
  bit           ovf;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_step();
    bit           done;
    bit           pop;
    logic [W-1:0] w;
    if (reset) begin
      capturing = 0; cap_q.delete();
      exp_valid = 0; exp_data = '0;
      frames = 0; drops = 0; ovf = 0;
      return;
    end
    done = 0;
    pop  = exp_valid && m_ready;
    if (capturing) begin
      cap_q.push_back(bit_in);
      if (cap_q.size() == W) begin
        done = 1;
        capturing = 0;
      end
    end else if (hit) begin
      capturing = 1;
      cap_q.delete();
      cap_q.push_back(bit_in);
      frames++;
    end
    if (done) begin
      w = '0;
      foreach (cap_q[i]) w = {w[W-2:0], cap_q[i]};
      if (!exp_valid || pop) begin
        exp_valid = 1;
        exp_data  = w;
      end else begin
        drops++;
        ovf = 1;
      end
    end else if (pop) begin
      exp_valid = 0;
    end
    if (clear_stats) begin
      frames = 0; drops = 0; ovf = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("m_valid",     32'(m_valid),     32'(exp_valid));
    chk("m_data",      32'(m_data),      32'(exp_data));
    chk("frame_count", 32'(frame_count), 32'(sat(frames, 65535)));
    chk("drop_count",  32'(drop_count),  32'(sat(drops, 65535)));
    chk("overflow",    32'(overflow),    32'(ovf));
    chk("s_valid",     32'(s_valid),     32'(exp_valid));
    chk("s_data",      32'(s_data),      32'(exp_data));
    chk("s_frames",    32'(s_frames),    32'(sat(frames, 3)));
    chk("s_drops",     32'(s_drops),     32'(sat(drops, 3)));
    chk("s_ovf",       32'(s_ovf),       32'(ovf));
  endtask

  task automatic cyc(input logic b, input logic h, input logic r, input logic rdy, input logic clr);
    bit_in = b; hit = h; reset = r; m_ready = rdy; clear_stats = clr;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic rdy_last);
    for (int i = W - 1; i >= 0; i--) begin
      cyc(w[i], (i == W - 1), 1'b0, (i == 0) ? rdy_last : 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [W-1:0] pat;
    int           fc0;
    bit_in = 0; hit = 0; reset = 1; m_ready = 0; clear_stats = 0;
    capturing = 0; exp_valid = 0; exp_data = '0; frames = 0; drops = 0; ovf = 0;

    // Reset state
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data",  32'(m_data),  32'h00);
    chk("rst_fc",    32'(frame_count), 32'd0);

    // 0xB2 frame, held then popped at t+10
    send_frame(8'hB2, 1'b0);
    chk("b2_valid", 32'(m_valid), 32'd1);
    chk("b2_data",  32'(m_data),  32'hB2);
    chk("b2_fc",    32'(frame_count), 32'd1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("b2_pop", 32'(m_valid), 32'd0);

    // Drop while output busy
    cyc(0, 0, 1, 0, 0);
    send_frame(8'hB2, 1'b0);
    send_frame(8'h5A, 1'b0);
    chk("drop_data", 32'(m_data), 32'hB2);
    chk("drop_cnt",  32'(drop_count), 32'd1);
    chk("drop_ovf",  32'(overflow), 32'd1);
    chk("drop_fc",   32'(frame_count), 32'd2);

    // Completion coinciding with a pop
    send_frame(8'h3C, 1'b1);
    chk("swap_valid", 32'(m_valid), 32'd1);
    chk("swap_data",  32'(m_data),  32'h3C);
    chk("swap_drop",  32'(drop_count), 32'd1);

    // Hits 2 apart start only one frame
    cyc(0, 0, 0, 1, 0);
    fc0 = frame_count;
    pat = 8'hAA;
    for (int i = W - 1; i >= 0; i--) begin
      cyc(pat[i], (i == 7 || i == 5 || i == 3), 1'b0, 1'b0, 1'b0);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("hit2_fc",   32'(frame_count), 32'(fc0 + 1));
    chk("hit2_data", 32'(m_data), 32'hAA);

    // Reset mid-capture (hit during reset is ignored), then a fresh 0xFF frame
    cyc(0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0);
    chk("abort_valid", 32'(m_valid), 32'd0);
    send_frame(8'hFF, 1'b0);
    chk("ff_data", 32'(m_data), 32'hFF);
    chk("ff_fc",   32'(frame_count), 32'd1);

    // clear_stats on the same cycle as a frame start: clear wins
    cyc(0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 1);
    for (int i = 0; i < W - 1; i++) cyc(0, 0, 0, 0, 0);
    chk("clr_fc",    32'(frame_count), 32'd0);
    chk("clr_valid", 32'(m_valid), 32'd1);
    chk("clr_data",  32'(m_data), 32'h80);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 199) == 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0));
    end

    // Saturation of the 2-bit counters
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) send_frame(8'(i * 37 + 1), 1'b1);
    chk("sat_small", 32'(s_frames), 32'd3);
    chk("sat_main",  32'(frame_count), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hit_payload_framer.md
Name: hit_payload_framer

Overview:
- Sits directly downstream of the serial pattern-detector FSM.
- Taps the same serial bit stream the detector sees, plus the detector's one-cycle match output.
- On a match, captures the next PAYLOAD_W serial bits as a frame and presents the frame on a valid/ready output port.
- Keeps saturating statistics counters for frames started and frames dropped.

Parameters:
- PAYLOAD_W, 8, number of serial bits captured per frame (>=2).
- CNT_W, 16, width of the frame and drop statistics counters.

Ports:
- clk, input, 1, single clock; all logic on posedge clk.
- reset, input, 1, synchronous active-high reset.
- bit_in, input, 1, serial data bit; same stream and cycle alignment as the detector's input.
- hit, input, 1, detector match output (Moore, registered); may assert on non-consecutive cycles only 2 apart.
- clear_stats, input, 1, synchronous clear of frame_count, drop_count and overflow.
- m_valid, output, 1, output frame register holds a word.
- m_ready, input, 1, consumer accepts the word when m_valid && m_ready.
- m_data, output, PAYLOAD_W, captured frame; first captured bit in the MSB.
- frame_count, output, CNT_W, frames started, saturating.
- drop_count, output, CNT_W, completed frames discarded because the output register was busy, saturating.
- overflow, output, 1, sticky; set on the first drop.

Behaviour:
- Reset (sync, highest priority): FSM=IDLE, bit counter=0, shift register=0, m_valid=0, m_data=0, frame_count=0, drop_count=0, overflow=0.
- FSM has two states:
  - IDLE: if hit=1, go to CAPTURE. bit_in in that same cycle is payload bit 0 (MSB). Bit counter=1; frame_count increments.
  - CAPTURE: shift bit_in in on every cycle and increment the bit counter. Go back to IDLE on the cycle the PAYLOAD_W-th bit is shifted in. hit is ignored throughout CAPTURE, including on the completing cycle.
- A frame is complete on the cycle its last bit is sampled. The word is available with m_valid=1 from the next cycle.
- Latency: hit sampled at cycle t gives m_valid high at t+PAYLOAD_W.
- At frame completion:
  - Output register free (m_valid=0, or m_valid && m_ready this cycle): load m_data and set m_valid=1.
  - Otherwise: discard the word, leave m_data unchanged, increment drop_count, set overflow.
- Pop without a completing frame: m_valid && m_ready with no frame completing clears m_valid. m_data holds its last value.
- m_data is stable while m_valid=1 && m_ready=0.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clear_stats zeroes frame_count, drop_count and overflow. It does not affect the FSM or the output register.
- clear_stats on the same cycle as an increment event: the clear wins and the counter goes to 0.
- reset mid-capture: the partial frame is discarded and no output is produced. The next hit after reset deasserts starts a fresh frame.
- hit on the cycle reset is high is ignored.
- m_ready is ignored when m_valid=0.

Test Plan:
- Reset, then idle with m_ready=1 -> m_valid=0, m_data=0x00, frame_count=0, drop_count=0, overflow=0.
- hit=1 at cycle t; bit_in=1,0,1,1,0,0,1,0 over cycles t..t+7; m_ready=0 -> m_valid rises at t+8, m_data=0xB2, frame_count=1. m_ready=1 at t+10 -> m_valid=0 at t+11.
- Keep m_ready=0 after a 0xB2 frame. Run a second frame 0x5A -> m_data stays 0xB2, drop_count=1, overflow=1, frame_count=2.
- Complete a frame 0x3C on the same cycle m_valid && m_ready pops 0xB2 -> next cycle m_valid=1, m_data=0x3C, drop_count unchanged.
- hit pulses at t, t+2 and t+4 (detector seeing 10101...) -> only one frame is started, frame_count increments by 1, and the captured word begins with the bit_in at t.
- reset after 4 captured bits, then a new hit with bits 0xFF -> no output from the aborted frame; m_data=0xFF with frame_count=1. A separate run with CNT_W=2 and 5 frames shows frame_count saturating at 3.
